strobe_monitor: RTL and testbench

Receive-side checker for the divided-clock strobe pair produced by the Costas clock divider: a once-per-frame tick and a trigger pulse at a fixed phase within the frame. Measures tick period, checks trigger placement, declares lock after consecutive good frames, and counts errors. Sits in the `clock` domain next to the loop logic that consumes the strobes; its `locked` output gates downstream use.

---
 rtl/strobe_monitor.sv | 167 ++++++++++++++++
 tb/tb_strobe_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_monitor.sv
// Receive-side checker for the divided-clock tick/trigger strobe pair: period measurement, lock, error counting.
// Define STROBE_MON_TRIG_CHECK_EN to enable trigger placement checking; otherwise trig_in is ignored.
module strobe_monitor #(
   parameter int unsigned PERIOD      = 15,
   parameter int unsigned TRIG_OFFSET = 13,
   parameter int unsigned LOCK_COUNT  = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        tick_in,
   input  logic        trig_in,
   input  logic        clear,
   output logic        locked,
   output logic        period_err,
   output logic        trig_err,
   output logic [7:0]  period_meas,
   output logic [15:0] err_count
);

   localparam int unsigned PH_MAX = 2 * PERIOD;
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MEAS_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned EXT_W  = ((PH_W > MEAS_W) ? PH_W : MEAS_W) + 1;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [GOOD_W-1:0]   good, good_nx;
   logic [PH_W-1:0]     ph;
   logic [EXT_W-1:0]    ph_ext;
   logic [MEAS_W-1:0]   ph_sat;
   logic [MEAS_W-1:0]   meas_nx;
   logic                tick_d;
   logic                tick_rise;
   logic                period_err_nx;
   logic                trig_err_nx;

   assign tick_rise = tick_in & ~tick_d;
   assign ph_ext    = EXT_W'(ph);
   assign ph_sat    = (ph_ext > EXT_W'(255)) ? 8'hFF : MEAS_W'(ph_ext);

   // Phase within the frame: 1 in the cycle after a tick rise, parks at twice the period
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_d <= 1'b0;
         ph     <= '0;
      end else begin
         tick_d <= tick_in;
         if (tick_rise)
            ph <= PH_W'(1);
         else if (ph != PH_W'(PH_MAX))
            ph <= ph + PH_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= SEARCH;
         good  <= '0;
      end else begin
         state <= state_nx;
         good  <= good_nx;
      end
   end

   // Lock tracking: good-period run length drives ACQUIRE -> LOCKED, any bad period drops back
   always_comb begin
      state_nx      = state;
      good_nx       = good;
      period_err_nx = 1'b0;
      meas_nx       = period_meas;
      case (state)
         SEARCH: begin
            if (tick_rise) begin
               state_nx = ACQUIRE;
               good_nx  = '0;
            end
         end
         ACQUIRE, LOCKED: begin
            if (tick_rise) begin
               meas_nx = ph_sat;
               if (ph == PH_W'(PERIOD)) begin
                  if (good >= GOOD_W'(LOCK_COUNT - 1)) begin
                     good_nx  = GOOD_W'(LOCK_COUNT);
                     state_nx = LOCKED;
                  end else begin
                     good_nx = good + GOOD_W'(1);
                  end
               end else begin
                  period_err_nx = 1'b1;
                  good_nx       = '0;
                  state_nx      = ACQUIRE;
               end
            end else if (ph == PH_W'(PH_MAX)) begin
               period_err_nx = 1'b1;
               good_nx       = '0;
               state_nx      = SEARCH;
            end
         end
         default: begin
            state_nx = SEARCH;
            good_nx  = '0;
         end
      endcase
   end

`ifdef STROBE_MON_TRIG_CHECK_EN
   logic trig_d;
   logic trig_rise;
   logic trig_seen;

   assign trig_rise = trig_in & ~trig_d;

   // A trigger rise coinciding with a tick rise belongs to the frame that is ending
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         trig_d    <= 1'b0;
         trig_seen <= 1'b0;
      end else begin
         trig_d <= trig_in;
         if (tick_rise)
            trig_seen <= 1'b0;
         else if (trig_rise && (ph == PH_W'(TRIG_OFFSET)))
            trig_seen <= 1'b1;
      end
   end

   always_comb begin
      trig_err_nx = 1'b0;
      if (state != SEARCH) begin
         if ((trig_rise && (ph != PH_W'(TRIG_OFFSET))) || (tick_rise && !trig_seen))
            trig_err_nx = 1'b1;
      end
   end
`else
   logic unused_trig;
   assign unused_trig = trig_in;
   assign trig_err_nx = 1'b0;
`endif

   // Registered outputs; clear takes priority over a same-cycle error increment
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         locked      <= 1'b0;
         period_err  <= 1'b0;
         trig_err    <= 1'b0;
         period_meas <= '0;
         err_count   <= '0;
      end else begin
         locked      <= (state_nx == LOCKED);
         period_err  <= period_err_nx;
         trig_err    <= trig_err_nx;
         period_meas <= meas_nx;
         if (clear)
            err_count <= '0;
         else if ((period_err | trig_err) && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_strobe_monitor.sv
// Directed bench for strobe_monitor: ideal lock, short period, tick loss, trigger shift, counter saturation/clear, async reset.
module tb_strobe_monitor;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        tick_in;
   logic        trig_in;
   logic        clear;
   logic        locked;
   logic        period_err;
   logic        trig_err;
   logic [7:0]  period_meas;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;

   logic       r_locked;
   logic       r_perr;
   logic       r_terr;
   logic [7:0] r_meas;
   int         f_perr;
   int         f_terr;

`ifdef STROBE_MON_TRIG_CHECK_EN
   localparam logic TC = 1'b1;
`else
   localparam logic TC = 1'b0;
`endif

   strobe_monitor #(
      .PERIOD      (15),
      .TRIG_OFFSET (13),
      .LOCK_COUNT  (4)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .tick_in     (tick_in),
      .trig_in     (trig_in),
      .clear       (clear),
      .locked      (locked),
      .period_err  (period_err),
      .trig_err    (trig_err),
      .period_meas (period_meas),
      .err_count   (err_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic t, input logic g, input logic c);
      tick_in = t;
      trig_in = g;
      clear   = c;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   // One frame: tick at index 0, trigger at index tp (0 = none), clear at index clr_at (-1 = none)
   task automatic frame(input int len, input int tp, input int clr_at);
      f_perr = 0;
      f_terr = 0;
      for (int k = 0; k < len; k++) begin
         cyc(k == 0, (tp != 0) && (k == tp), k == clr_at);
         if (k == 0) begin
            r_locked = locked;
            r_perr   = period_err;
            r_terr   = trig_err;
            r_meas   = period_meas;
         end else begin
            f_perr += int'(period_err);
            f_terr += int'(trig_err);
         end
      end
      tick_in = 1'b0;
      trig_in = 1'b0;
      clear   = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      tick_in = 1'b0;
      trig_in = 1'b0;
      clear   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_perr", 32'(period_err), 32'd0);
      chk("rst_terr", 32'(trig_err), 32'd0);
      chk("rst_meas", 32'(period_meas), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      reset_n = 1'b1;
      idle(2);

      // Ideal source: lock one cycle after the 5th tick rise
      frame(15, 13, -1);
      chk("e1_locked", 32'(r_locked), 32'd0);
      chk("e1_meas", 32'(r_meas), 32'd0);
      for (int i = 0; i < 3; i++) frame(15, 13, -1);
      chk("e4_locked", 32'(r_locked), 32'd0);
      chk("e4_meas", 32'(r_meas), 32'd15);
      frame(15, 13, -1);
      chk("e5_locked", 32'(r_locked), 32'd1);
      chk("e5_meas", 32'(r_meas), 32'd15);
      chk("e5_perr", 32'(r_perr), 32'd0);
      chk("e5_terr", 32'(r_terr), 32'd0);
      chk("e5_errcnt", 32'(err_count), 32'd0);

      // One 14-cycle period while locked
      frame(14, 13, -1);
      chk("f_short_rise_locked", 32'(r_locked), 32'd1);
      frame(15, 13, -1);
      chk("f0_perr", 32'(r_perr), 32'd1);
      chk("f0_locked", 32'(r_locked), 32'd0);
      chk("f0_meas", 32'(r_meas), 32'd14);
      chk("f0_terr", 32'(r_terr), 32'd0);
      chk("f0_body_perr", 32'(f_perr), 32'd0);
      chk("f0_errcnt", 32'(err_count), 32'd1);
      for (int i = 0; i < 3; i++) frame(15, 13, -1);
      chk("f3_locked", 32'(r_locked), 32'd0);
      frame(15, 13, -1);
      chk("f4_locked", 32'(r_locked), 32'd1);
      chk("f4_meas", 32'(r_meas), 32'd15);

      // Tick stops: timeout when ph reaches 30
      idle(15);
      chk("to_pre_perr", 32'(period_err), 32'd0);
      chk("to_pre_locked", 32'(locked), 32'd1);
      idle(1);
      chk("to_perr", 32'(period_err), 32'd1);
      chk("to_locked", 32'(locked), 32'd0);
      idle(3);
      chk("to_perr_gone", 32'(period_err), 32'd0);
      chk("to_errcnt", 32'(err_count), 32'd2);
      frame(15, 13, -1);
      chk("g1_perr", 32'(r_perr), 32'd0);
      chk("g1_terr", 32'(r_terr), 32'd0);
      chk("g1_meas", 32'(r_meas), 32'd15);
      for (int i = 0; i < 3; i++) frame(15, 13, -1);
      chk("g4_locked", 32'(r_locked), 32'd0);
      frame(15, 13, -1);
      chk("g5_locked", 32'(r_locked), 32'd1);
      chk("g5_errcnt", 32'(err_count), 32'd2);

      // Trigger moved to phase 12 for two frames
      frame(15, 12, -1);
      chk("h1_rise_terr", 32'(r_terr), 32'd0);
      chk("h1_body_terr", 32'(f_terr), TC ? 32'd1 : 32'd0);
      chk("h1_errcnt", 32'(err_count), TC ? 32'd3 : 32'd2);
      frame(15, 12, -1);
      chk("h2_rise_terr", 32'(r_terr), TC ? 32'd1 : 32'd0);
      chk("h2_body_terr", 32'(f_terr), TC ? 32'd1 : 32'd0);
      chk("h2_locked", 32'(r_locked), 32'd1);
      chk("h2_perr", 32'(r_perr), 32'd0);
      chk("h2_errcnt", 32'(err_count), TC ? 32'd5 : 32'd2);
      frame(15, 13, -1);
      chk("h3_rise_terr", 32'(r_terr), TC ? 32'd1 : 32'd0);
      chk("h3_body_terr", 32'(f_terr), 32'd0);
      frame(15, 13, -1);
      chk("h4_rise_terr", 32'(r_terr), 32'd0);
      chk("h4_locked", 32'(r_locked), 32'd1);
      chk("h4_errcnt", 32'(err_count), TC ? 32'd6 : 32'd2);

      // Saturation: preload 0xFFFE, then three period errors
      force dut.err_count = 16'hFFFE;
      #1;
      release dut.err_count;
      frame(5, 0, -1);
      chk("j1_perr", 32'(r_perr), 32'd0);
      frame(5, 0, -1);
      chk("j2_perr", 32'(r_perr), 32'd1);
      chk("j2_errcnt", 32'(err_count), 32'hFFFF);
      frame(5, 0, -1);
      frame(5, 0, -1);
      chk("j4_perr", 32'(r_perr), 32'd1);
      chk("j4_errcnt", 32'(err_count), 32'hFFFF);
      frame(5, 0, 1);
      chk("j5_perr", 32'(r_perr), 32'd1);
      chk("j5_clear_errcnt", 32'(err_count), 32'd0);

      // Relock, then asynchronous reset mid-frame
      frame(15, 13, -1);
      chk("k1_perr", 32'(r_perr), 32'd1);
      for (int i = 0; i < 4; i++) frame(15, 13, -1);
      chk("k5_locked", 32'(r_locked), 32'd1);
      chk("k5_errcnt", 32'(err_count), 32'd1);
      idle(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_locked", 32'(locked), 32'd0);
      chk("arst_perr", 32'(period_err), 32'd0);
      chk("arst_terr", 32'(trig_err), 32'd0);
      chk("arst_meas", 32'(period_meas), 32'd0);
      chk("arst_errcnt", 32'(err_count), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle(2);
      frame(15, 13, -1);
      chk("l1_perr", 32'(r_perr), 32'd0);
      chk("l1_meas", 32'(r_meas), 32'd0);
      for (int i = 0; i < 3; i++) frame(15, 13, -1);
      chk("l4_locked", 32'(r_locked), 32'd0);
      frame(15, 13, -1);
      chk("l5_locked", 32'(r_locked), 32'd1);
      chk("l5_meas", 32'(r_meas), 32'd15);
      chk("l5_errcnt", 32'(err_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
